vector_alu_sequencer: RTL and testbench
=======================================

Name: vector_alu_sequencer

Overview:
- Issue-side controller for the 21-bit lane ALU (operand/funct/flag in, result out).
- Accepts a vector command (funct, length), reads element pairs from the vector register file, and drives the ALU operand ports one element per cycle.
- Captures each ALU result and writes it back with a valid/ready handshake.
- Sits between the vector decode stage and the lane ALU.

Parameters:
- DATA_W, 21, element width; must match the ALU operand width.
- IDX_W, 4, element index width; maximum vector length is 2**IDX_W (16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  command valid.
- start_ready  out  1  high only in IDLE.
- start_funct  in  3  ALU function: 000 move, 010 add, 011 sub, 111 mul.
- start_len  in  IDX_W+1  element count, 0..16.
- rd_idx  out  IDX_W  register-file read index; combinational read, data valid in the same cycle.
- rd_a  in  DATA_W  element i of source A.
- rd_b  in  DATA_W  element i of source B.
- alu_op1  out  DATA_W  registered operand to ALU op1.
- alu_op2  out  DATA_W  registered operand to ALU op2.
- alu_funct  out  3  registered funct to ALU.
- alu_flag  out  1  ALU enable; high only while the ALU stage holds a valid element.
- alu_result  in  DATA_W  combinational ALU result.
- wr_en  out  1  write-back valid.
- wr_ready  in  1  write-back ready.
- wr_idx  out  IDX_W  write-back element index.
- wr_data  out  DATA_W  write-back data.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse, coincident with done, for an illegal funct.

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE.
  - All outputs go to 0, except start_ready, which is 1.
  - Pipeline valids clear, counters clear.
  - Reset during RUN/DRAIN aborts the command; no further writes occur.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - start_ready=1.
  - On start_valid, latch funct and len.
  - Illegal funct (001, 100, 101, 110): go to FINISH with err set; no reads or writes.
  - len=0: go to FINISH; done only, no writes.
  - Otherwise: go to RUN with issue index 0.
- Pipeline:
  - Three stages: S0 read, S1 ALU, S2 write-back; one element per cycle when not stalled.
  - S0 (RUN): rd_idx = issue index. On advance, {rd_a, rd_b, idx} load into alu_op1/alu_op2/S1 idx, and the S1 valid is set.
  - S1: alu_flag = S1 valid. On advance, alu_result is registered into wr_data, idx into wr_idx, and the S2 valid (wr_en) is set.
  - Latency: element read in cycle t appears on wr_en/wr_data in cycle t+2 when there is no stall.
- Stall:
  - When wr_en=1 and wr_ready=0, S0, S1 and S2 all hold.
  - alu_op1/op2/funct/flag stay constant, so the combinational result stays stable.
  - wr_idx/wr_data stay constant.
- Write handshake:
  - A transfer occurs when wr_en && wr_ready.
  - wr_en stays high until the transfer; data may not change while pending.
- RUN → DRAIN: after issuing index len-1 (on advance). DRAIN issues no new reads; rd_idx holds its last value.
- DRAIN → FINISH: in the cycle the last element transfers and S1 is empty.
- FINISH: done=1 for one cycle (err=1 as well if illegal); next state IDLE.
- alu_flag:
  - 0 whenever S1 is empty.
  - The sequencer never samples alu_result while alu_flag=0, because the ALU holds its previous value then.
- Arithmetic: performed by the ALU modulo 2**DATA_W. Sub wraps. Mul keeps the low 21 bits. The sequencer does no width extension.
- Ordering: wr_idx strictly increases 0..len-1 within a command, with no gaps or duplicates.
- start_valid outside IDLE is ignored (start_ready=0).
- Back-to-back commands: the next command may be accepted in the cycle after FINISH.

Decomposition:
- Shared package vec_alu_pkg:
  - funct constants: FN_MOV=3'b000, FN_ADD=3'b010, FN_SUB=3'b011, FN_MUL=3'b111.
  - is_legal_funct function.
  - DATA_W constant.
  - Sequencer state enum.
- One natural sub-module: vector_alu_pipe_stage, a DATA_W+IDX_W+1 register slice with hold (stall) input, instantiated for S1 and S2.
- The ALU itself is instantiated alongside this block in the lane, not inside it.

Test Plan:
- Add, len=4, wr_ready=1, A={1,2,3,0x1FFFFF}, B={10,20,30,1} → writes idx0..3 = {11,22,33,0x000000}; first wr_en 2 cycles after accept; done with last write+1.
- Sub/mul wrap: funct 011, A=0, B=1 → 0x1FFFFF. Funct 111, A=0x800, B=0x800 → 0x000000 (low 21 bits of 2**22).
- Backpressure: len=3 move, wr_ready low for 3 cycles on idx1 → alu_op*/wr_data/wr_idx stable throughout; writes in order 0,1,2; no drops.
- Illegal funct 101, len=5 → no wr_en, alu_flag stays 0; done and err pulse together 1 cycle after accept; start_ready high next cycle.
- len=0 add → done only, err=0, no wr_en. len=16 → 16 writes, idx 0..15, no wrap to 0.
- rst asserted mid-RUN at idx2 → outputs immediately 0 (start_ready=1), no further wr_en; new command after reset completes normally.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// -----------------------------------------------------------------------------
// vec_alu_pkg
// Shared definitions for the vector ALU sequencer slice:
//   DATA_W  element width (must match the lane ALU operand width)
//   IDX_W   element index width; maximum vector length is 2**IDX_W
//   FN_*    ALU function encodings understood by the lane ALU
//   seq_state_t  sequencer FSM states
//   is_legal_funct()  true for the four functions the ALU implements
// -----------------------------------------------------------------------------
package vec_alu_pkg;

   localparam int DATA_W = 21;
   localparam int IDX_W  = 4;

   localparam logic [2:0] FN_MOV = 3'b000;
   localparam logic [2:0] FN_ADD = 3'b010;
   localparam logic [2:0] FN_SUB = 3'b011;
   localparam logic [2:0] FN_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FINISH
   } seq_state_t;

   function automatic logic is_legal_funct(input logic [2:0] funct);
      return funct inside {FN_MOV, FN_ADD, FN_SUB, FN_MUL};
   endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// vector_alu_sequencer_if
// Bundles every non-clock/reset signal of the sequencer:
//   command     start_valid/start_ready/start_funct/start_len
//   reg file    rd_idx (out), rd_a/rd_b (combinational read data, in)
//   lane ALU    alu_op1/alu_op2/alu_funct/alu_flag (out), alu_result (in)
//   write-back  wr_en/wr_idx/wr_data (out), wr_ready (in)
//   status      done, err (one-cycle pulses)
// Modports: master = sequencer side, slave = surrounding lane/environment.
// -----------------------------------------------------------------------------
interface vector_alu_sequencer_if;
   import vec_alu_pkg::*;

   logic              start_valid;
   logic              start_ready;
   logic [2:0]        start_funct;
   logic [IDX_W:0]    start_len;

   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;

   logic [DATA_W-1:0] alu_op1;
   logic [DATA_W-1:0] alu_op2;
   logic [2:0]        alu_funct;
   logic              alu_flag;
   logic [DATA_W-1:0] alu_result;

   logic              wr_en;
   logic              wr_ready;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;

   logic              done;
   logic              err;

   modport master (
      input  start_valid, start_funct, start_len, rd_a, rd_b, alu_result, wr_ready,
      output start_ready, rd_idx, alu_op1, alu_op2, alu_funct, alu_flag,
             wr_en, wr_idx, wr_data, done, err
   );

   modport slave (
      output start_valid, start_funct, start_len, rd_a, rd_b, alu_result, wr_ready,
      input  start_ready, rd_idx, alu_op1, alu_op2, alu_funct, alu_flag,
             wr_en, wr_idx, wr_data, done, err
   );

endinterface

// File: rtl/vector_alu_pipe_stage.sv
// -----------------------------------------------------------------------------
// vector_alu_pipe_stage
// One pipeline register slice: a valid bit plus PAYLOAD_W bits of payload
// (by default DATA_W data + IDX_W index).
//   clk, rst   clock, asynchronous active-high reset
//   hold       freeze the slice (downstream stall)
//   in_valid   upstream element present
//   in_data    upstream payload
//   out_valid  slice holds a valid element
//   out_data   registered payload
// The payload is only loaded for valid elements, so an empty slot keeps the
// last real element on its outputs and nothing downstream sees new values.
// -----------------------------------------------------------------------------
module vector_alu_pipe_stage
   import vec_alu_pkg::*;
#(
   parameter int PAYLOAD_W = DATA_W + IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data
);

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its neighbours, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/vector_alu_sequencer.sv
// -----------------------------------------------------------------------------
// vector_alu_sequencer
// Issue-side controller for the lane ALU. Accepts a vector command
// (funct, length), streams element pairs from the register file into the
// ALU one per cycle and writes each result back through a valid/ready port.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts any command in flight
//   bus   vector_alu_sequencer_if.master (command, reg-file read, ALU,
//         write-back and status signals)
// Widths DATA_W / IDX_W come from vec_alu_pkg.
//
// Pipeline: S0 read (rd_idx = issue index) -> S1 ALU operands -> S2 write-back.
// A pending write that is not accepted (wr_en && !wr_ready) freezes all three
// stages, which keeps the ALU inputs and hence its result stable.
// -----------------------------------------------------------------------------
module vector_alu_sequencer
   import vec_alu_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   vector_alu_sequencer_if.master bus
);

   localparam int S1_W = 2 * DATA_W + IDX_W;
   localparam int S2_W = DATA_W + IDX_W;

   seq_state_t        state;
   seq_state_t        state_nxt;

   logic [2:0]        funct_q;
   logic [IDX_W:0]    len_q;
   logic [IDX_W-1:0]  issue_idx;
   logic              illegal_q;

   logic              accept;
   logic              stall;
   logic              advance;
   logic              s0_valid;
   logic              last_issue;
   logic              wr_xfer;

   logic              s1_valid;
   logic [S1_W-1:0]   s1_data;
   logic [IDX_W-1:0]  s1_idx;
   logic              s2_valid;
   logic [S2_W-1:0]   s2_data;

   assign accept     = (state == ST_IDLE) && bus.start_valid;
   assign stall      = bus.wr_en && !bus.wr_ready;
   assign advance    = !stall;
   assign s0_valid   = (state == ST_RUN);
   assign last_issue = ({1'b0, issue_idx} == (len_q - 1'b1));
   assign wr_xfer    = bus.wr_en && bus.wr_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt       = state;
      bus.start_ready = 1'b0;
      bus.done        = 1'b0;
      bus.err         = 1'b0;

      case (state)
         ST_IDLE: begin
            bus.start_ready = 1'b1;
            if (bus.start_valid) begin
               // Illegal funct and empty vectors skip the pipeline entirely.
               if (!is_legal_funct(bus.start_funct) || (bus.start_len == '0)) begin
                  state_nxt = ST_FINISH;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (advance && last_issue) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The element leaving S2 is the last one once S1 has emptied.
            if (wr_xfer && !s1_valid) begin
               state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            bus.done  = 1'b1;
            bus.err   = illegal_q;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------- command / issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         funct_q   <= '0;
         len_q     <= '0;
         issue_idx <= '0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         funct_q   <= bus.start_funct;
         len_q     <= bus.start_len;
         issue_idx <= '0;
         illegal_q <= !is_legal_funct(bus.start_funct);
      end else if (s0_valid && advance && !last_issue) begin
         // The index stops at len-1 so rd_idx holds its last value in DRAIN.
         issue_idx <= issue_idx + 1'b1;
      end
   end

   assign bus.rd_idx    = issue_idx;
   // funct is constant for the whole command, so the latched copy serves
   // directly as the registered ALU function.
   assign bus.alu_funct = funct_q;

   // ------------------------------------------------------ S1: ALU stage
   vector_alu_pipe_stage #(
      .PAYLOAD_W (S1_W)
   ) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .hold      (stall),
      .in_valid  (s0_valid),
      .in_data   ({bus.rd_a, bus.rd_b, issue_idx}),
      .out_valid (s1_valid),
      .out_data  (s1_data)
   );

   assign bus.alu_op1  = s1_data[S1_W-1 -: DATA_W];
   assign bus.alu_op2  = s1_data[IDX_W +: DATA_W];
   assign s1_idx       = s1_data[IDX_W-1:0];
   assign bus.alu_flag = s1_valid;

   // ---------------------------------------------- S2: write-back stage
   // alu_result is only captured when S1 is valid, i.e. while alu_flag=1;
   // with the flag low the ALU output is a stale value.
   vector_alu_pipe_stage #(
      .PAYLOAD_W (S2_W)
   ) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .hold      (stall),
      .in_valid  (s1_valid),
      .in_data   ({bus.alu_result, s1_idx}),
      .out_valid (s2_valid),
      .out_data  (s2_data)
   );

   assign bus.wr_en   = s2_valid;
   assign bus.wr_data = s2_data[S2_W-1 -: DATA_W];
   assign bus.wr_idx  = s2_data[IDX_W-1:0];

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_alu_sequencer
// Directed bench for vector_alu_sequencer. Provides a register-file model,
// a combinational lane-ALU model and a write-back monitor; each feature task
// drives one scenario and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_vector_alu_sequencer;
   import vec_alu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vector_alu_sequencer_if bus ();

   vector_alu_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Register file and lane ALU models
   logic [DATA_W-1:0] mem_a [16];
   logic [DATA_W-1:0] mem_b [16];

   assign bus.rd_a = mem_a[bus.rd_idx];
   assign bus.rd_b = mem_b[bus.rd_idx];

   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_funct)
         FN_MOV:  bus.alu_result = bus.alu_op1;
         FN_ADD:  bus.alu_result = bus.alu_op1 + bus.alu_op2;
         FN_SUB:  bus.alu_result = bus.alu_op1 - bus.alu_op2;
         FN_MUL:  bus.alu_result = bus.alu_op1 * bus.alu_op2;
         default: bus.alu_result = '0;
      endcase
   end

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: samples outputs on the falling edge
   logic [IDX_W-1:0]  log_idx  [$];
   logic [DATA_W-1:0] log_data [$];
   int                log_cyc  [$];
   int done_cnt   = 0;
   int done_cyc   = -1;
   int err_cnt    = 0;
   int err_orphan = 0;
   int flag_cnt   = 0;
   int wren_cnt   = 0;

   always @(negedge clk) begin
      if (bus.wr_en && bus.wr_ready) begin
         log_idx.push_back(bus.wr_idx);
         log_data.push_back(bus.wr_data);
         log_cyc.push_back(cyc);
      end
      if (bus.done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         if (bus.err) err_cnt = err_cnt + 1;
      end
      if (bus.err && !bus.done) err_orphan = err_orphan + 1;
      if (bus.alu_flag) flag_cnt = flag_cnt + 1;
      if (bus.wr_en) wren_cnt = wren_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [2:0] f, input logic [IDX_W:0] l, output int acc);
      @(posedge clk);
      #1;
      bus.start_valid = 1'b1;
      bus.start_funct = f;
      bus.start_len   = l;
      @(posedge clk);
      #1;
      acc = cyc;
      bus.start_valid = 1'b0;
      bus.start_funct = 3'b000;
      bus.start_len   = '0;
   endtask

   task automatic wait_done(input int max_cycles);
      int  d0;
      bit  seen;
      d0   = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (done_cnt != d0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_total++;
         $display("FAIL done_timeout: no done within %0d cycles", max_cycles);
      end
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1;
      bus.start_valid = 1'b0;
      bus.start_funct = 3'b000;
      bus.start_len   = '0;
      bus.wr_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (bus.start_ready !== 1'b1) $display("FAIL rst_start_ready: got %b exp 1", bus.start_ready); else n_pass++;
      n_total++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b exp 0", bus.wr_en); else n_pass++;
      n_total++; if (bus.alu_flag !== 1'b0) $display("FAIL rst_alu_flag: got %b exp 0", bus.alu_flag); else n_pass++;
      n_total++; if (bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL rst_done_err: got %b%b exp 00", bus.done, bus.err); else n_pass++;
      n_total++; if (bus.rd_idx !== '0) $display("FAIL rst_rd_idx: got %0h exp 0", bus.rd_idx); else n_pass++;
      n_total++; if (bus.alu_op1 !== '0 || bus.alu_op2 !== '0) $display("FAIL rst_alu_ops: got %0h/%0h exp 0/0", bus.alu_op1, bus.alu_op2); else n_pass++;
      n_total++; if (bus.alu_funct !== 3'b000) $display("FAIL rst_alu_funct: got %b exp 000", bus.alu_funct); else n_pass++;
      n_total++; if (bus.wr_data !== '0 || bus.wr_idx !== '0) $display("FAIL rst_wr_bus: got %0h/%0h exp 0/0", bus.wr_idx, bus.wr_data); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [DATA_W-1:0] exp_d [4] = '{21'd11, 21'd22, 21'd33, 21'h000000};
      int acc, base, e0;
      mem_a[0] = 21'd1;  mem_a[1] = 21'd2;  mem_a[2] = 21'd3;  mem_a[3] = 21'h1FFFFF;
      mem_b[0] = 21'd10; mem_b[1] = 21'd20; mem_b[2] = 21'd30; mem_b[3] = 21'd1;
      base = log_idx.size();
      e0   = err_cnt;
      start_cmd(FN_ADD, 5'd4, acc);
      wait_done(40);
      n_total++; if (log_idx.size() - base !== 4) $display("FAIL add_count: got %0d exp 4", log_idx.size() - base); else n_pass++;
      for (int i = 0; i < 4 && base + i < log_idx.size(); i++) begin
         n_total++;
         if (log_idx[base+i] !== i[IDX_W-1:0] || log_data[base+i] !== exp_d[i])
            $display("FAIL add_elem%0d: got idx %0d data %0h exp idx %0d data %0h", i, log_idx[base+i], log_data[base+i], i, exp_d[i]);
         else n_pass++;
      end
      if (log_idx.size() - base == 4) begin
         n_total++; if (log_cyc[base] !== acc + 2) $display("FAIL add_latency: got cycle %0d exp %0d", log_cyc[base], acc + 2); else n_pass++;
         n_total++; if (done_cyc !== log_cyc[base+3] + 1) $display("FAIL add_done_cycle: got %0d exp %0d", done_cyc, log_cyc[base+3] + 1); else n_pass++;
      end
      n_total++; if (err_cnt !== e0) $display("FAIL add_err: got %0d err pulses exp 0", err_cnt - e0); else n_pass++;
   endtask

   task automatic test_wrap();
      int acc, base;
      // sub wraps: 0 - 1
      mem_a[0] = 21'd0; mem_b[0] = 21'd1;
      base = log_idx.size();
      start_cmd(FN_SUB, 5'd1, acc);
      wait_done(20);
      n_total++;
      if (log_idx.size() - base !== 1) $display("FAIL sub_count: got %0d exp 1", log_idx.size() - base);
      else if (log_data[base] !== 21'h1FFFFF) $display("FAIL sub_wrap: got %0h exp 1fffff", log_data[base]);
      else n_pass++;
      // mul keeps low 21 bits: 0x800*0x800 = 2**22 -> 0; 0x1FFFFF*2 -> 0x1FFFFE
      mem_a[0] = 21'h800;    mem_b[0] = 21'h800;
      mem_a[1] = 21'h1FFFFF; mem_b[1] = 21'd2;
      base = log_idx.size();
      start_cmd(FN_MUL, 5'd2, acc);
      wait_done(20);
      n_total++;
      if (log_idx.size() - base !== 2) $display("FAIL mul_count: got %0d exp 2", log_idx.size() - base);
      else if (log_data[base] !== 21'h000000 || log_data[base+1] !== 21'h1FFFFE)
         $display("FAIL mul_wrap: got %0h,%0h exp 0,1ffffe", log_data[base], log_data[base+1]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] exp_d [3] = '{21'd5, 21'd6, 21'd7};
      int  acc, base;
      bit  found;
      mem_a[0] = 21'd5;  mem_a[1] = 21'd6;  mem_a[2] = 21'd7;
      mem_b[0] = 21'd50; mem_b[1] = 21'd60; mem_b[2] = 21'd70;
      base  = log_idx.size();
      found = 1'b0;
      start_cmd(FN_MOV, 5'd3, acc);
      for (int i = 0; i < 20; i++) begin
         if (bus.wr_en && bus.wr_idx == 1) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!found) begin
         n_total++;
         $display("FAIL bp_find_idx1: wr_idx 1 never presented");
      end else begin
         bus.wr_ready = 1'b0;
         for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
               @(posedge clk);
               #1;
            end
            n_total++;
            if (bus.wr_en !== 1'b1 || bus.wr_idx !== 4'd1 || bus.wr_data !== 21'd6)
               $display("FAIL bp_wr_hold%0d: got en %b idx %0d data %0h exp 1/1/6", j, bus.wr_en, bus.wr_idx, bus.wr_data);
            else n_pass++;
            n_total++;
            if (bus.alu_op1 !== 21'd7 || bus.alu_op2 !== 21'd70 || bus.alu_flag !== 1'b1 || bus.alu_funct !== FN_MOV)
               $display("FAIL bp_alu_hold%0d: got op1 %0h op2 %0h flag %b fn %b exp 7/46/1/000", j, bus.alu_op1, bus.alu_op2, bus.alu_flag, bus.alu_funct);
            else n_pass++;
         end
         @(posedge clk);
         #1;
         bus.wr_ready = 1'b1;
      end
      bus.wr_ready = 1'b1;
      wait_done(30);
      n_total++; if (log_idx.size() - base !== 3) $display("FAIL bp_count: got %0d exp 3", log_idx.size() - base); else n_pass++;
      for (int i = 0; i < 3 && base + i < log_idx.size(); i++) begin
         n_total++;
         if (log_idx[base+i] !== i[IDX_W-1:0] || log_data[base+i] !== exp_d[i])
            $display("FAIL bp_elem%0d: got idx %0d data %0h exp idx %0d data %0h", i, log_idx[base+i], log_data[base+i], i, exp_d[i]);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      int acc, base, d0, e0, f0, w0;
      base = log_idx.size();
      d0 = done_cnt; e0 = err_cnt; f0 = flag_cnt; w0 = wren_cnt;
      start_cmd(3'b101, 5'd5, acc);
      wait_done(10);
      n_total++; if (done_cyc !== acc) $display("FAIL ill_done_cycle: got %0d exp %0d", done_cyc, acc); else n_pass++;
      n_total++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 1) $display("FAIL ill_done_err: got done %0d err %0d exp 1/1", done_cnt - d0, err_cnt - e0); else n_pass++;
      n_total++; if (wren_cnt !== w0 || log_idx.size() !== base) $display("FAIL ill_no_write: got %0d wr_en cycles exp 0", wren_cnt - w0); else n_pass++;
      n_total++; if (flag_cnt !== f0) $display("FAIL ill_flag: got %0d flag cycles exp 0", flag_cnt - f0); else n_pass++;
      tick();
      n_total++; if (bus.start_ready !== 1'b1) $display("FAIL ill_ready_after: got %b exp 1", bus.start_ready); else n_pass++;
   endtask

   task automatic test_len0();
      int acc, base, d0, e0, w0;
      base = log_idx.size();
      d0 = done_cnt; e0 = err_cnt; w0 = wren_cnt;
      start_cmd(FN_ADD, 5'd0, acc);
      wait_done(10);
      n_total++; if (done_cnt - d0 !== 1 || done_cyc !== acc) $display("FAIL len0_done: got %0d pulses at %0d exp 1 at %0d", done_cnt - d0, done_cyc, acc); else n_pass++;
      n_total++; if (err_cnt !== e0) $display("FAIL len0_err: got %0d exp 0", err_cnt - e0); else n_pass++;
      n_total++; if (wren_cnt !== w0 || log_idx.size() !== base) $display("FAIL len0_write: got %0d wr_en cycles exp 0", wren_cnt - w0); else n_pass++;
   endtask

   task automatic test_len16();
      int acc, base;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = DATA_W'(3 * i);
         mem_b[i] = 21'd100;
      end
      base = log_idx.size();
      start_cmd(FN_ADD, 5'd16, acc);
      wait_done(60);
      n_total++; if (log_idx.size() - base !== 16) $display("FAIL len16_count: got %0d exp 16", log_idx.size() - base); else n_pass++;
      for (int i = 0; i < 16 && base + i < log_idx.size(); i++) begin
         n_total++;
         if (log_idx[base+i] !== i[IDX_W-1:0] || log_data[base+i] !== DATA_W'(3 * i + 100))
            $display("FAIL len16_elem%0d: got idx %0d data %0h exp idx %0d data %0h", i, log_idx[base+i], log_data[base+i], i, 3 * i + 100);
         else n_pass++;
      end
      if (log_idx.size() - base == 16) begin
         n_total++; if (done_cyc !== log_cyc[base+15] + 1) $display("FAIL len16_done_cycle: got %0d exp %0d", done_cyc, log_cyc[base+15] + 1); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int  acc, base, w0;
      bit  found;
      for (int i = 0; i < 8; i++) begin
         mem_a[i] = DATA_W'(i + 1);
         mem_b[i] = DATA_W'(i);
      end
      found = 1'b0;
      start_cmd(FN_ADD, 5'd8, acc);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.rd_idx == 2) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_total++;
         $display("FAIL rmid_find_idx2: rd_idx 2 never seen");
      end
      rst = 1'b1;
      #1;
      w0 = wren_cnt;
      n_total++; if (bus.wr_en !== 1'b0 || bus.alu_flag !== 1'b0) $display("FAIL rmid_valids: got wr_en %b flag %b exp 0/0", bus.wr_en, bus.alu_flag); else n_pass++;
      n_total++; if (bus.start_ready !== 1'b1) $display("FAIL rmid_start_ready: got %b exp 1", bus.start_ready); else n_pass++;
      n_total++; if (bus.rd_idx !== '0 || bus.alu_op1 !== '0 || bus.wr_data !== '0) $display("FAIL rmid_zero: got rd %0h op1 %0h wd %0h exp 0", bus.rd_idx, bus.alu_op1, bus.wr_data); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) tick();
      n_total++; if (wren_cnt !== w0) $display("FAIL rmid_no_write: got %0d wr_en cycles exp 0", wren_cnt - w0); else n_pass++;
      // new command after reset: 100-1 = 99, 5-10 wraps to 0x1FFFFB
      mem_a[0] = 21'd100; mem_b[0] = 21'd1;
      mem_a[1] = 21'd5;   mem_b[1] = 21'd10;
      base = log_idx.size();
      start_cmd(FN_SUB, 5'd2, acc);
      wait_done(20);
      n_total++;
      if (log_idx.size() - base !== 2) $display("FAIL rmid_after_count: got %0d exp 2", log_idx.size() - base);
      else if (log_idx[base] !== 4'd0 || log_data[base] !== 21'd99 || log_idx[base+1] !== 4'd1 || log_data[base+1] !== 21'h1FFFFB)
         $display("FAIL rmid_after_data: got %0d:%0h %0d:%0h exp 0:63 1:1ffffb", log_idx[base], log_data[base], log_idx[base+1], log_data[base+1]);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      test_reset();
      test_add();
      test_wrap();
      test_backpressure();
      test_illegal();
      test_len0();
      test_len16();
      test_reset_mid();
      n_total++; if (err_orphan !== 0) $display("FAIL err_without_done: got %0d exp 0", err_orphan); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
